flex_rcv_deserializer: RTL and testbench
========================================

// Module: flex_rcv_deserializer
// PURPOSE
//  Parametrised serial-to-parallel receive deserializer, successor to the fixed 8-bit LSB-first shift register.
//  Collects DATA_WIDTH data bits (plus optional parity) on shift_enable strobes from the receive timer.
//  Presents each completed word through a valid/ready holding register, with parity and overrun flags.
//  Sits between the receive timer/start-bit detector and the receive FIFO / control FSM.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, 2..32
//  MSB_FIRST   0  0: first received bit lands in parallel_out[0]; 1: first bit lands in parallel_out[DATA_WIDTH-1]
//  PARITY_EN   0  1: one parity bit follows the data bits
//  PARITY_ODD  0  0: even parity; 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  shift_enable   in   1           sample serial_in this cycle
//  serial_in      in   1           serial data bit
//  frame_start    in   1           abort partial frame, restart bit count
//  out_ready      in   1           consumer accepts parallel_out this cycle
//  clear_errors   in   1           clear sticky overrun_error
//  parallel_out   out  DATA_WIDTH  held received word
//  out_valid      out  1           parallel_out / parity_error valid
//  parity_error   out  1           parity mismatch of held word
//  overrun_error  out  1           sticky: completed frame dropped
//  busy           out  1           frame in progress (state != IDLE)
//  bit_count      out  $clog2(DATA_WIDTH+2)  bits sampled in current frame
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; shift reg, parallel_out, bit_count = 0; out_valid, parity_error, overrun_error, busy = 0.
//  - Priority at each edge: rst > frame_start > shift_enable.
//  - FSM: IDLE -> SHIFT on shift_enable (that bit is bit 0); SHIFT counts data bits;
//    after bit DATA_WIDTH-1: PARITY_EN ? PARITY : commit + IDLE; PARITY: next shift_enable samples parity, commit + IDLE.
//  - Shift: MSB_FIRST=0 shifts right, new bit enters MSB; MSB_FIRST=1 shifts left, new bit enters bit 0.
//  - bit_count increments per sampled bit (data and parity); returns to 0 at commit.
//  - Commit happens at the same edge that samples the final bit (zero extra latency): holding reg loads the
//    post-shift word; parity_error <= (^data ^ parity_bit) != PARITY_ODD, or 0 when PARITY_EN=0.
//  - Handshake: out_valid stays high until an edge with out_ready=1. Accept without commit -> out_valid=0.
//    Accept and commit at the same edge -> new word loaded, out_valid stays 1, no overrun.
//  - Commit while out_valid=1 and out_ready=0: new word dropped, held word/parity_error unchanged, overrun_error <= 1.
//  - overrun_error cleared only by clear_errors or rst; a new overrun at the same edge as clear_errors wins (stays 1).
//  - frame_start: shift reg and bit_count cleared, state IDLE; with shift_enable in the same cycle the bit is
//    taken as bit 0 of the new frame (state SHIFT, bit_count=1). The holding register is unaffected.
//  - shift_enable low: no state, count or data change. serial_in is ignored when shift_enable=0.
//  - rst mid-frame or with out_valid=1: everything returns to reset values; the partial or held word is lost.
// TESTING
//  1. Defaults: shift 1,0,1,1,0,0,1,0 -> parallel_out=8'h4D, out_valid=1 on the edge of the 8th bit.
//  2. MSB_FIRST=1, same bits -> parallel_out=8'hB2; out_ready=1 for one cycle -> out_valid=0.
//  3. PARITY_EN=1, PARITY_ODD=0: data 8'h4D with parity 0 -> parity_error=0; parity 1 -> parity_error=1.
//  4. Hold out_ready=0, receive two frames -> first word kept, overrun_error=1; clear_errors -> 0.
//  5. frame_start after 3 bits, then 8 new bits 8'hFF -> parallel_out=8'hFF, bit_count back to 0.
//  6. rst asserted after 5 bits with out_valid=1 -> all outputs 0 next edge; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/flex_rcv_deserializer.sv
// rtl/flex_rcv_deserializer.sv - parametrised serial-to-parallel receive deserializer with valid/ready holding register
module flex_rcv_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  shift_enable,
    input  logic                                  serial_in,
    input  logic                                  frame_start,
    input  logic                                  out_ready,
    input  logic                                  clear_errors,
    output logic [DATA_WIDTH-1:0]                 parallel_out,
    output logic                                  out_valid,
    output logic                                  parity_error,
    output logic                                  overrun_error,
    output logic                                  busy,
    output logic [$clog2(DATA_WIDTH+2)-1:0]       bit_count
);

    localparam int CW = $clog2(DATA_WIDTH + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic [CW-1:0] LAST_DATA_IDX = CW'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_word;
    logic                  commit_perr;

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ovr_q, ovr_d;
    logic                  ovr_new;

    // Frame assembly: frame_start rebases the frame first, then a strobe samples into the fresh frame.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        shifted     = '0;
        commit      = 1'b0;
        commit_word = '0;
        commit_perr = 1'b0;

        if (frame_start) begin
            state_d = ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end

        if (MSB_FIRST != 0) begin
            shifted = {shift_d[DATA_WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, shift_d[DATA_WIDTH-1:1]};
        end

        if (shift_enable) begin
            if (state_d == ST_PARITY) begin
                // Parity bit is checked against the already assembled word, never shifted in.
                commit      = 1'b1;
                commit_word = shift_d;
                commit_perr = ((^shift_d) ^ serial_in) != (PARITY_ODD != 0);
                state_d     = ST_IDLE;
                shift_d     = '0;
                cnt_d       = '0;
            end else if (cnt_d == LAST_DATA_IDX) begin
                if (PARITY_EN != 0) begin
                    state_d = ST_PARITY;
                    shift_d = shifted;
                    cnt_d   = cnt_d + 1'b1;
                end else begin
                    commit      = 1'b1;
                    commit_word = shifted;
                    state_d     = ST_IDLE;
                    shift_d     = '0;
                    cnt_d       = '0;
                end
            end else begin
                state_d = ST_SHIFT;
                shift_d = shifted;
                cnt_d   = cnt_d + 1'b1;
            end
        end
    end

    // Holding register handshake and sticky overrun flag.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        ovr_new = 1'b0;

        if (commit) begin
            if (valid_q && !out_ready) begin
                ovr_new = 1'b1;
            end else begin
                word_d  = commit_word;
                perr_d  = commit_perr;
                valid_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (clear_errors) begin
            ovr_d = 1'b0;
        end
        if (ovr_new) begin
            ovr_d = 1'b1;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out  = word_q;
    assign out_valid     = valid_q;
    assign parity_error  = perr_q;
    assign overrun_error = ovr_q;
    assign busy          = (state_q != ST_IDLE);
    assign bit_count     = cnt_q;

endmodule

// File: tb/tb_flex_rcv_deserializer.sv
// tb/tb_flex_rcv_deserializer.sv - randomized and directed bench for flex_rcv_deserializer against a bit-list model
module tb_flex_rcv_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the default instance, index 1 the MSB-first even-parity instance.
    logic [1:0] rst, se, si, fs, rdy, clr;

    logic [7:0] po_a, po_b;
    logic       ov_a, ov_b, pe_a, pe_b, oe_a, oe_b, bz_a, bz_b;
    logic [3:0] bc_a, bc_b;

    flex_rcv_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst[0]), .shift_enable(se[0]), .serial_in(si[0]), .frame_start(fs[0]),
        .out_ready(rdy[0]), .clear_errors(clr[0]), .parallel_out(po_a), .out_valid(ov_a),
        .parity_error(pe_a), .overrun_error(oe_a), .busy(bz_a), .bit_count(bc_a)
    );

    flex_rcv_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst[1]), .shift_enable(se[1]), .serial_in(si[1]), .frame_start(fs[1]),
        .out_ready(rdy[1]), .clear_errors(clr[1]), .parallel_out(po_b), .out_valid(ov_b),
        .parity_error(pe_b), .overrun_error(oe_b), .busy(bz_b), .bit_count(bc_b)
    );

    int p_msb[2] = '{0, 1};
    int p_pe[2]  = '{0, 1};
    int p_odd[2] = '{0, 0};

    // Model: list of bits received in the current frame plus the consumer-visible holding state.
    logic [15:0] m_bits[2];
    int          m_n[2];
    logic [7:0]  m_word[2];
    logic        m_valid[2], m_perr[2], m_ovr[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input int d);
        logic       do_commit;
        logic [7:0] w;
        int         ones;
        logic       pbit;
        logic       p_err;
        do_commit = 1'b0;
        w = '0;
        p_err = 1'b0;
        if (rst[d]) begin
            m_n[d] = 0; m_bits[d] = '0; m_word[d] = '0;
            m_valid[d] = 1'b0; m_perr[d] = 1'b0; m_ovr[d] = 1'b0;
            return;
        end
        if (fs[d]) m_n[d] = 0;
        if (se[d]) begin
            m_bits[d][m_n[d]] = si[d];
            m_n[d]++;
            if (m_n[d] == 8 + p_pe[d]) begin
                do_commit = 1'b1;
                ones = 0;
                for (int i = 0; i < 8; i++) begin
                    if (p_msb[d] != 0) w[7-i] = m_bits[d][i];
                    else               w[i]   = m_bits[d][i];
                    ones += int'(m_bits[d][i]);
                end
                if (p_pe[d] != 0) begin
                    pbit  = m_bits[d][8];
                    p_err = (((ones + int'(pbit)) % 2) != p_odd[d]);
                end
                m_n[d] = 0;
            end
        end
        if (do_commit) begin
            if (m_valid[d] && !rdy[d]) begin
                m_ovr[d] = 1'b1;
            end else begin
                m_word[d]  = w;
                m_perr[d]  = p_err;
                m_valid[d] = 1'b1;
                if (clr[d]) m_ovr[d] = 1'b0;
            end
        end else begin
            if (rdy[d]) m_valid[d] = 1'b0;
            if (clr[d]) m_ovr[d] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model(0);
        model(1);
        #1;
        check("a_word",  {24'd0, po_a}, {24'd0, m_word[0]});
        check("a_valid", {31'd0, ov_a}, {31'd0, m_valid[0]});
        check("a_perr",  {31'd0, pe_a}, {31'd0, m_perr[0]});
        check("a_ovr",   {31'd0, oe_a}, {31'd0, m_ovr[0]});
        check("a_busy",  {31'd0, bz_a}, (m_n[0] != 0) ? 32'd1 : 32'd0);
        check("a_cnt",   {28'd0, bc_a}, m_n[0]);
        check("b_word",  {24'd0, po_b}, {24'd0, m_word[1]});
        check("b_valid", {31'd0, ov_b}, {31'd0, m_valid[1]});
        check("b_perr",  {31'd0, pe_b}, {31'd0, m_perr[1]});
        check("b_ovr",   {31'd0, oe_b}, {31'd0, m_ovr[1]});
        check("b_busy",  {31'd0, bz_b}, (m_n[1] != 0) ? 32'd1 : 32'd0);
        check("b_cnt",   {28'd0, bc_b}, m_n[1]);
        rst = '0; se = '0; fs = '0; rdy = '0; clr = '0;
        si = 2'($urandom_range(0, 3));
    endtask

    task automatic send_bit(input int d, input logic b);
        se[d] = 1'b1;
        si[d] = b;
        step();
    endtask

    task automatic send_byte(input int d, input logic [7:0] bits_in_order);
        for (int i = 7; i >= 0; i--) send_bit(d, bits_in_order[i]);
    endtask

    task automatic accept(input int d);
        rdy[d] = 1'b1;
        step();
    endtask

    initial begin
        rst = 2'b11; se = '0; si = '0; fs = '0; rdy = '0; clr = '0;
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_bits[d] = '0; m_word[d] = '0;
            m_valid[d] = 1'b0; m_perr[d] = 1'b0; m_ovr[d] = 1'b0;
        end
        step();
        check("reset_word", {24'd0, po_a}, 32'h0);
        check("reset_valid", {31'd0, ov_a}, 32'd0);

        // LSB-first: bits arrive 1,0,1,1,0,0,1,0.
        send_byte(0, 8'b1011_0010);
        check("t1_word", {24'd0, po_a}, 32'h4D);
        check("t1_valid", {31'd0, ov_a}, 32'd1);
        accept(0);
        check("t1_accept", {31'd0, ov_a}, 32'd0);

        // MSB-first, same bit order, even parity bit 0 (popcount 4).
        send_byte(1, 8'b1011_0010);
        check("t2_busy_parity", {31'd0, bz_b}, 32'd1);
        check("t2_cnt_parity", {28'd0, bc_b}, 32'd8);
        send_bit(1, 1'b0);
        check("t2_word", {24'd0, po_b}, 32'hB2);
        check("t2_perr", {31'd0, pe_b}, 32'd0);
        accept(1);
        check("t2_accept", {31'd0, ov_b}, 32'd0);

        // 8'h4D sent MSB first, then good and bad parity.
        send_byte(1, 8'h4D);
        send_bit(1, 1'b0);
        check("t3_word", {24'd0, po_b}, 32'h4D);
        check("t3_perr_ok", {31'd0, pe_b}, 32'd0);
        accept(1);
        send_byte(1, 8'h4D);
        send_bit(1, 1'b1);
        check("t3_perr_bad", {31'd0, pe_b}, 32'd1);
        accept(1);

        // Overrun with the consumer stalled, then clear.
        send_byte(0, 8'b1011_0010);
        send_byte(0, 8'hFF);
        check("t4_kept", {24'd0, po_a}, 32'h4D);
        check("t4_ovr", {31'd0, oe_a}, 32'd1);
        clr[0] = 1'b1;
        step();
        check("t4_clr", {31'd0, oe_a}, 32'd0);
        accept(0);

        // frame_start aborts a 3-bit partial frame.
        send_bit(0, 1'b0); send_bit(0, 1'b0); send_bit(0, 1'b1);
        fs[0] = 1'b1;
        step();
        check("t5_cnt_abort", {28'd0, bc_a}, 32'd0);
        send_byte(0, 8'hFF);
        check("t5_word", {24'd0, po_a}, 32'hFF);
        check("t5_cnt", {28'd0, bc_a}, 32'd0);

        // Reset mid-frame with a held word.
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
        rst[0] = 1'b1;
        step();
        check("t6_word", {24'd0, po_a}, 32'h0);
        check("t6_valid", {31'd0, ov_a}, 32'd0);
        check("t6_cnt", {28'd0, bc_a}, 32'd0);
        send_byte(0, 8'b1011_0010);
        check("t6_after", {24'd0, po_a}, 32'h4D);

        // Randomized traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int d = 0; d < 2; d++) begin
                se[d]  = ($urandom_range(0, 99) < 60);
                fs[d]  = ($urandom_range(0, 99) < 3);
                rdy[d] = ($urandom_range(0, 99) < 35);
                clr[d] = ($urandom_range(0, 99) < 5);
                rst[d] = ($urandom_range(0, 299) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
